dl_skid_buf: RTL and testbench

- Two-entry valid/ready elastic stage (skid buffer) for the consumer side of the pipeline-stage interface.
- Accepts a word from an upstream producer and presents it to a downstream reader one cycle later.
- Its `in_ready` is a pure function of registered state, so the downstream stall path is broken combinationally.
- Sits between RISC-V pipeline stages (e.g. fetch→decode) wherever the downstream `ready` is late-arriving, and supports a pipeline flush.

---
 rtl/dl_skid_buf_pkg.sv | 21 ++
 rtl/dl_skid_buf_reg.sv | 15 +
 rtl/dl_skid_buf.sv | 131 +++++++++++++
 tb/tb_dl_skid_buf.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dl_skid_buf_pkg.sv
// Shared encodings for the dl_skid_buf elastic stage: occupancy states and
// the next-value selections used in front of the two data registers.
package dl_skid_buf_pkg;

  // The state encoding equals the occupancy, so the state register doubles as count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_IN   = 2'd1,
    SEL_SKID = 2'd2,
    SEL_ZERO = 2'd3
  } sel_e;

  localparam int MAX_COUNT = 2;

endpackage

// File: rtl/dl_skid_buf_reg.sv
// Library register dl_reg: a plain NUM_BITS-wide flop with no enable or reset;
// hold, load and clear behaviour are supplied by the mux placed in front of it.
module dl_reg #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic [NUM_BITS-1:0] d,
  output logic [NUM_BITS-1:0] q
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready skid buffer. Every output is a flop, so a late-arriving
// out_ready never reaches in_ready combinationally.
`ifndef __DL_SKID_BUF_V__
`define __DL_SKID_BUF_V__

module dl_skid_buf
  import dl_skid_buf_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [NUM_BITS-1:0] out_data,
  input  logic                out_ready,
  output logic [1:0]          count
);

  state_e              state_p1;
  state_e              state_nxt;
  logic                in_ready_p1;
  logic                out_valid_p1;
  sel_e                main_sel;
  sel_e                skid_sel;
  logic [NUM_BITS-1:0] main_p1;
  logic [NUM_BITS-1:0] skid_p1;
  logic [NUM_BITS-1:0] main_d;
  logic [NUM_BITS-1:0] skid_d;
  logic                in_fire;
  logic                out_fire;

  function automatic logic [NUM_BITS-1:0] next_word(
    input sel_e                sel,
    input logic [NUM_BITS-1:0] cur,
    input logic [NUM_BITS-1:0] in_w,
    input logic [NUM_BITS-1:0] skid_w
  );
    logic [NUM_BITS-1:0] w;
    case (sel)
      SEL_IN:   w = in_w;
      SEL_SKID: w = skid_w;
      SEL_ZERO: w = '0;
      default:  w = cur;
    endcase
    return w;
  endfunction

  assign in_fire  = in_valid & in_ready_p1;
  assign out_fire = out_valid_p1 & out_ready;

  // Next-state and register-load selection; reset outranks flush, flush outranks handshakes.
  always_comb begin
    state_nxt = state_p1;
    main_sel  = SEL_HOLD;
    skid_sel  = SEL_HOLD;
    if (rst) begin
      state_nxt = EMPTY;
      main_sel  = SEL_ZERO;
      skid_sel  = SEL_ZERO;
    end else if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_sel  = SEL_IN;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_sel = SEL_IN;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_sel  = SEL_IN;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_sel  = SEL_SKID;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage boundary: control flops, with handshake flags precomputed from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1     <= EMPTY;
      in_ready_p1  <= 1'b1;
      out_valid_p1 <= 1'b0;
    end else begin
      state_p1     <= state_nxt;
      in_ready_p1  <= (state_nxt != FULL);
      out_valid_p1 <= (state_nxt != EMPTY);
    end
  end

  assign main_d = next_word(main_sel, main_p1, in_data, skid_p1);
  assign skid_d = next_word(skid_sel, skid_p1, in_data, skid_p1);

  // Stage boundary: data flops.
  dl_reg #(.NUM_BITS(NUM_BITS)) u_main (
    .clk (clk),
    .d   (main_d),
    .q   (main_p1)
  );

  dl_reg #(.NUM_BITS(NUM_BITS)) u_skid (
    .clk (clk),
    .d   (skid_d),
    .q   (skid_p1)
  );

  assign in_ready  = in_ready_p1;
  assign out_valid = out_valid_p1;
  assign out_data  = main_p1;
  assign count     = state_p1;

endmodule

`endif

// File: tb/tb_dl_skid_buf.sv
// Bench for dl_skid_buf: directed scenarios then random traffic, all checked
// against a FIFO-queue reference model of at most two words.
module tb_dl_skid_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  count;

  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] mq[$];
  logic        m_known = 1'b0;
  logic        m_zero  = 1'b0;

  always #5 clk = ~clk;

  dl_skid_buf #(.NUM_BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, recheck that the
  // handshake outputs ignore the new inputs, then advance the reference model.
  task automatic cycle(input logic r, input logic fl, input logic iv,
                       input logic [31:0] d, input logic ordy);
    int  sz;
    logic ir;
    logic ov;
    @(negedge clk);
    sz = mq.size();
    ir = (sz < 2);
    ov = (sz > 0);
    if (m_known) begin
      check_eq("count", {30'd0, count}, sz);
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, ir});
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, ov});
      if (ov) check_eq("out_data", out_data, mq[0]);
      else if (m_zero) check_eq("out_data_rst", out_data, 32'd0);
    end
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (m_known) begin
      check_eq("in_ready_comb", {31'd0, in_ready}, {31'd0, ir});
      check_eq("out_valid_comb", {31'd0, out_valid}, {31'd0, ov});
    end
    if (r) begin
      mq.delete();
      m_known = 1'b1;
      m_zero  = 1'b1;
    end else if (m_known) begin
      if (fl) begin
        mq.delete();
      end else begin
        if (ov && ordy) void'(mq.pop_front());
        if (iv && ir) begin
          mq.push_back(d);
          m_zero = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    out_ready = 1'b0;

    cycle(1'b1, 1'b0, 1'b1, 32'h99, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h99, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming with the reader always ready.
    cycle(1'b0, 1'b0, 1'b1, 32'h11, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h22, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h33, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure: third word must wait upstream until space frees.
    cycle(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Simultaneous input and output transfer in ONE.
    cycle(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h6, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush from FULL while a new word is offered.
    cycle(1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h7, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush in ONE with an accepted-looking input and an output transfer together.
    cycle(1'b0, 1'b0, 1'b1, 32'h8, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h9, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-operation from FULL.
    cycle(1'b0, 1'b0, 1'b1, 32'h3, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h4, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hF, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 999) == 0),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom,
            ($urandom_range(0, 2) != 0));
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
